// File: rtl/usb_pkg.sv
// Shared types and default timing for the USB link controller.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_GAP       = 3'd2,
    ST_TX        = 3'd3,
    ST_WAIT_RESP = 3'd4
  } link_state_t;

  localparam int TURN_CYCLES_DEF  = 16;
  localparam int IDLE_MIN_DEF     = 8;
  localparam int RESP_TIMEOUT_DEF = 600;
  localparam int RX_MAX_DEF       = 8192;
  localparam int CNT_W            = 14;

endpackage

// File: rtl/line_idle_counter.sv
// Counts consecutive J-state cycles on the line, saturating at IDLE_MIN.
module line_idle_counter
  import usb_pkg::*;
#(
  parameter int IDLE_MIN = IDLE_MIN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_i,
  input  logic d_minus_i,
  output logic idle_ok_o
);

  localparam int             W   = $clog2(IDLE_MIN + 1);
  localparam logic [W-1:0]   SAT = W'(IDLE_MIN);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!(d_plus_i && !d_minus_i)) cnt_d = '0;
    else if (cnt_q != SAT)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign idle_ok_o = (cnt_q == SAT);

endmodule

// File: rtl/usb_link_ctrl.sv
// USB link-layer bus ownership FSM: arbitrates RX/TX, enforces turnaround gap,
// response timeout and RX overrun abort. All outputs come from registers.
module usb_link_ctrl
  import usb_pkg::*;
#(
  parameter int TURN_CYCLES  = TURN_CYCLES_DEF,
  parameter int IDLE_MIN     = IDLE_MIN_DEF,
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
  parameter int RX_MAX       = RX_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       rx_active,
  input  logic       rx_eop,
  input  logic       tx_req,
  input  logic       tx_expect_resp,
  input  logic       tx_done,
  output logic       tx_grant,
  output logic       line_oe,
  output logic       rx_enable,
  output logic       rx_abort,
  output logic       resp_timeout,
  output logic [2:0] link_state
);

  // Counter holds (cycles in state - 1), so each limit fires on its Nth cycle.
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  link_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;
  logic             tx_q, rx_en_q, abort_q, tmo_q;
  logic             abort_d, tmo_d;
  logic             idle_ok;

  line_idle_counter #(.IDLE_MIN(IDLE_MIN)) u_idle (
    .clk       (clk),
    .rst       (rst),
    .d_plus_i  (d_plus),
    .d_minus_i (d_minus),
    .idle_ok_o (idle_ok)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    abort_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_active) state_d = ST_RX;
        else if (tx_req && idle_ok) begin
          state_d = ST_TX;
          exp_d   = tx_expect_resp;
        end
      end
      ST_RX: begin
        if (rx_eop) state_d = ST_GAP;
        else if (cnt_q == RX_LAST) begin
          state_d = ST_GAP;
          abort_d = 1'b1;
        end
      end
      ST_GAP:  if (cnt_q == TURN_LAST) state_d = ST_IDLE;
      ST_TX:   if (tx_done) state_d = exp_q ? ST_WAIT_RESP : ST_GAP;
      ST_WAIT_RESP: begin
        if (rx_active) state_d = ST_RX;
        else if (cnt_q == RESP_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      tx_q    <= 1'b0;
      rx_en_q <= 1'b1;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tx_q    <= (state_d == ST_TX);
      rx_en_q <= (state_d == ST_IDLE) || (state_d == ST_RX) || (state_d == ST_WAIT_RESP);
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
    end
  end

  assign tx_grant     = tx_q;
  assign line_oe      = tx_q;
  assign rx_enable    = rx_en_q;
  assign rx_abort     = abort_q;
  assign resp_timeout = tmo_q;
  assign link_state   = state_q;

endmodule
